// File: rtl/tsc_pkg.sv
// Shared types and constants for the TSC two-rail generator.
//   tsc_state_e : controller states
//   NUM_PAT     : number of self-test patterns
//   TEST_PAT    : self-test patterns, bit order {x0, y0, x1, y1}
//   LAST_PAT    : index of the final (non-codeword) pattern
package tsc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StApply,
        StSample,
        StDone
    } tsc_state_e;

    localparam int unsigned NUM_PAT = 5;

    // The four per-bit codeword classes, then the all-zero non-codeword.
    localparam logic [3:0] TEST_PAT [NUM_PAT] = '{
        4'b0101,
        4'b0110,
        4'b1001,
        4'b1010,
        4'b0000
    };

    localparam logic [2:0] LAST_PAT = 3'(NUM_PAT - 1);

endpackage

// File: rtl/tsc_pat_eval.sv
// Combinational judge of the checker response for one self-test pattern.
//   pat_idx  : index of the pattern currently driven on the rails
//   chk_x    : checker final_x
//   chk_y    : checker final_y
//   pat_good : checker behaved correctly for this pattern
module tsc_pat_eval
    import tsc_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [2:0]   pat_idx,
    input  logic [W-1:0] chk_x,
    input  logic [W-1:0] chk_y,
    output logic         pat_good
);

    always_comb begin
        pat_good = 1'b0;
        if (pat_idx == LAST_PAT) begin
            // Non-codeword input: the checker must flag it on at least one bit.
            pat_good = |(~(chk_x ^ chk_y));
        end else begin
            // Codeword input: every output bit pair must be complementary.
            pat_good = &(chk_x ^ chk_y);
        end
    end

endmodule

// File: rtl/tsc_two_rail_gen.sv
// Two-rail encoder and checker self-test sequencer.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : data pair handshake, in_d0/in_d1 the data words
//   x0/y0, x1/y1        : registered two-rail outputs to the checker
//   out_valid/out_ready : output word handshake
//   test_req            : level request for a checker self-test
//   chk_x, chk_y        : checker final_x / final_y
//   test_busy           : self-test patterns being applied
//   test_done           : one-cycle pulse at the end of a self-test
//   test_pass/test_fail : sticky result of the last completed self-test
module tsc_two_rail_gen
    import tsc_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned HOLD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_d0,
    input  logic [W-1:0] in_d1,
    output logic [W-1:0] x0,
    output logic [W-1:0] y0,
    output logic [W-1:0] x1,
    output logic [W-1:0] y1,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic         test_req,
    input  logic [W-1:0] chk_x,
    input  logic [W-1:0] chk_y,
    output logic         test_busy,
    output logic         test_done,
    output logic         test_pass,
    output logic         test_fail
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    // With HOLD == 1 the single hold cycle is already the sample cycle.
    localparam tsc_state_e FIRST_ST = (HOLD == 1) ? StSample : StApply;

    tsc_state_e   state_q, state_d;
    logic [2:0]   pat_q, pat_d;
    logic [3:0]   hold_q, hold_d;
    logic         fail_acc_q, fail_acc_d;
    logic         pass_q, pass_d;
    logic         fail_q, fail_d;
    logic         valid_q, valid_d;
    logic [W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;

    logic         pat_good;
    logic         start_test;
    logic [3:0]   pat_bits;

    tsc_pat_eval #(
        .W(W)
    ) u_pat_eval (
        .pat_idx (pat_q),
        .chk_x   (chk_x),
        .chk_y   (chk_y),
        .pat_good(pat_good)
    );

    assign in_ready = (state_q == StIdle) & ~test_req & (~valid_q | out_ready);

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        hold_d     = hold_q;
        fail_acc_d = fail_acc_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        valid_d    = valid_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        start_test = 1'b0;

        if (in_valid && in_ready) begin
            x0_d    = in_d0;
            y0_d    = ~in_d0;
            x1_d    = in_d1;
            y1_d    = ~in_d1;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (test_req) begin
                    if (valid_q) begin
                        state_d = StDrain;
                    end else begin
                        start_test = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (!valid_q || out_ready) begin
                    start_test = 1'b1;
                end
            end
            StApply: begin
                hold_d = hold_q + 4'd1;
                if (hold_d == HOLD_LAST) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                fail_acc_d = fail_acc_q | ~pat_good;
                if (pat_q == LAST_PAT) begin
                    state_d = StDone;
                    pass_d  = ~fail_acc_d;
                    fail_d  = fail_acc_d;
                end else begin
                    pat_d   = pat_q + 3'd1;
                    hold_d  = 4'd0;
                    state_d = FIRST_ST;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Parks the rail registers on the idle codeword so DONE and IDLE
        // present (0, 1s, 0, 1s) once the patterns are released.
        if (start_test) begin
            state_d    = FIRST_ST;
            pat_d      = 3'd0;
            hold_d     = 4'd0;
            fail_acc_d = 1'b0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            valid_d    = 1'b0;
            x0_d       = '0;
            y0_d       = '1;
            x1_d       = '0;
            y1_d       = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pat_q      <= 3'd0;
            hold_q     <= 4'd0;
            fail_acc_q <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            valid_q    <= 1'b0;
            x0_q       <= '0;
            y0_q       <= '1;
            x1_q       <= '0;
            y1_q       <= '1;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            hold_q     <= hold_d;
            fail_acc_q <= fail_acc_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            valid_q    <= valid_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
        end
    end

    assign test_busy = (state_q == StApply) || (state_q == StSample);
    assign test_done = (state_q == StDone);
    assign test_pass = pass_q;
    assign test_fail = fail_q;
    assign out_valid = valid_q;

    assign pat_bits = TEST_PAT[pat_q];

    always_comb begin
        x0 = x0_q;
        y0 = y0_q;
        x1 = x1_q;
        y1 = y1_q;
        if (test_busy) begin
            x0 = {W{pat_bits[3]}};
            y0 = {W{pat_bits[2]}};
            x1 = {W{pat_bits[1]}};
            y1 = {W{pat_bits[0]}};
        end
    end

endmodule

// File: tb/tb_tsc_two_rail_gen.sv
module tb_tsc_two_rail_gen;

    localparam int W    = 16;
    localparam int HOLD = 2;

    logic         clk, rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, test_req;
    logic [W-1:0] in_d0, in_d1, x0, y0, x1, y1, chk_x, chk_y;
    logic         test_busy, test_done, test_pass, test_fail;
    logic         fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the output word.
    logic         m_valid;
    logic [W-1:0] m_x0, m_y0, m_x1, m_y1;

    // Self-test patterns as tuples (x0, y0, x1, y1).
    logic [3:0] pat_tbl [5] = '{4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b0000};

    tsc_two_rail_gen #(
        .W   (W),
        .HOLD(HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_d0    (in_d0),
        .in_d1    (in_d1),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .test_req (test_req),
        .chk_x    (chk_x),
        .chk_y    (chk_y),
        .test_busy(test_busy),
        .test_done(test_done),
        .test_pass(test_pass),
        .test_fail(test_fail)
    );

    always #5 clk = ~clk;

    // Reference two-rail checker cell, or a stuck-at-zero broken one.
    function automatic void ref_chk(input logic [W-1:0] a0, b0, a1, b1, input logic flt,
                                    output logic [W-1:0] fx, output logic [W-1:0] fy);
        fx = flt ? '0 : ((a0 & a1) | (b0 & b1));
        fy = flt ? '0 : ((a0 & b1) | (b0 & a1));
    endfunction

    always_comb begin
        chk_x = '0;
        chk_y = '0;
        ref_chk(x0, y0, x1, y1, fault, chk_x, chk_y);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rails_model();
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("x0", {16'd0, x0}, {16'd0, m_x0});
        check("y0", {16'd0, y0}, {16'd0, m_y0});
        check("x1", {16'd0, x1}, {16'd0, m_x1});
        check("y1", {16'd0, y1}, {16'd0, m_y1});
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_x0 = '0; m_y0 = '1; m_x1 = '0; m_y1 = '1;
    endtask

    // Called #1 after a posedge; drives one data-path cycle and checks it.
    task automatic data_cycle(input logic v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                              input logic rdy);
        logic exp_rdy;
        in_valid = v; in_d0 = d0; in_d1 = d1; out_ready = rdy; test_req = 1'b0;
        #1;
        exp_rdy = !m_valid || rdy;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        if (v && exp_rdy) begin
            m_valid = 1'b1;
            m_x0 = d0; m_y0 = ~d0; m_x1 = d1; m_y1 = ~d1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check_rails_model();
        check("busy_data", {31'd0, test_busy}, 32'd0);
    endtask

    // Runs one self-test. drain: a word is pending and out_ready is held low.
    // abort_p < 5 asserts reset at the start of that pattern.
    task automatic run_test(input logic flt, input logic drain, input int abort_p);
        logic [W-1:0] px0, py0, px1, py1, fx, fy;
        logic         exp_fail, good;
        fault = flt;
        test_req = 1'b1; in_valid = 1'b1; in_d0 = W'($urandom); in_d1 = W'($urandom);
        out_ready = !drain;
        #1;
        check("req_blocks_in", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        test_req = 1'b0; in_valid = 1'b0;
        if (drain) begin
            for (int i = 0; i < 3; i++) begin
                check("drain_busy", {31'd0, test_busy}, 32'd0);
                check("drain_ready", {31'd0, in_ready}, 32'd0);
                check_rails_model();
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        m_valid = 1'b0;
        exp_fail = 1'b0;
        for (int p = 0; p < 5; p++) begin
            px0 = pat_tbl[p][3] ? '1 : '0;
            py0 = pat_tbl[p][2] ? '1 : '0;
            px1 = pat_tbl[p][1] ? '1 : '0;
            py1 = pat_tbl[p][0] ? '1 : '0;
            for (int h = 0; h < HOLD; h++) begin
                check("busy", {31'd0, test_busy}, 32'd1);
                check("done_early", {31'd0, test_done}, 32'd0);
                check("pass_cleared", {30'd0, test_pass, test_fail}, 32'd0);
                check("ready_in_test", {31'd0, in_ready}, 32'd0);
                check("valid_in_test", {31'd0, out_valid}, 32'd0);
                check("pat_rails", {x0[7:0], y0[7:0], x1[7:0], y1[7:0]},
                      {px0[7:0], py0[7:0], px1[7:0], py1[7:0]});
                if (p == abort_p) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check("rst_done", {31'd0, test_done}, 32'd0);
                    check("rst_busy", {31'd0, test_busy}, 32'd0);
                    check("rst_result", {30'd0, test_pass, test_fail}, 32'd0);
                    model_reset();
                    check_rails_model();
                    @(posedge clk);
                    #6 rst_n = 1'b1;
                    @(posedge clk); #1;
                    check("post_rst_done", {31'd0, test_done}, 32'd0);
                    check("post_rst_result", {30'd0, test_pass, test_fail}, 32'd0);
                    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
                    return;
                end
                if (h == HOLD - 1) begin
                    ref_chk(px0, py0, px1, py1, flt, fx, fy);
                    good = (p < 4) ? (fx == ~fy) : (|(~(fx ^ fy)));
                    exp_fail = exp_fail | !good;
                end
                @(posedge clk); #1;
            end
        end
        model_reset();
        check("done", {31'd0, test_done}, 32'd1);
        check("done_busy", {31'd0, test_busy}, 32'd0);
        check("result", {30'd0, test_pass, test_fail}, {30'd0, !exp_fail, exp_fail});
        check("done_ready", {31'd0, in_ready}, 32'd0);
        check_rails_model();
        @(posedge clk); #1;
        check("done_pulse", {31'd0, test_done}, 32'd0);
        check("result_sticky", {30'd0, test_pass, test_fail}, {30'd0, !exp_fail, exp_fail});
        fault = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; fault = 1'b0;
        in_valid = 1'b0; in_d0 = '0; in_d1 = '0; out_ready = 1'b0; test_req = 1'b0;
        model_reset();
        #12;
        check_rails_model();
        check("reset_test", {29'd0, test_busy, test_done, test_pass | test_fail}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_rails_model();
        check("reset_ready", {31'd0, in_ready}, 32'd1);

        data_cycle(1'b1, 16'hA5A5, 16'h00FF, 1'b1);
        check("a5_rails", {x0, y0}, 32'hA5A5_5A5A);
        check("ff_rails", {x1, y1}, 32'h00FF_FF00);
        for (int i = 0; i < 3; i++) data_cycle(1'b1, W'($urandom), W'($urandom), 1'b1);
        for (int i = 0; i < 40; i++)
            data_cycle(1'($urandom), W'($urandom), W'($urandom), ($urandom_range(0, 3) != 0));
        data_cycle(1'b0, '0, '0, 1'b1);

        run_test(1'b0, 1'b0, 5);
        data_cycle(1'b1, W'($urandom), W'($urandom), 1'b0);
        run_test(1'b0, 1'b1, 5);
        run_test(1'b1, 1'b0, 5);
        run_test(1'b0, 1'b0, 5);
        run_test(1'b0, 1'b0, 2);
        for (int i = 0; i < 10; i++)
            data_cycle(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
